// File: rtl/vital_state_integrator.sv
// Virtual-pet vital state integrator: three saturating 2-bit levels driven by
// event pulses and a decay prescaler, plus a four-phase sleep/wake FSM.
module vital_state_integrator #(
    parameter int unsigned DECAY_PERIOD  = 1024,
    parameter int unsigned DROWSY_CYCLES = 64,
    parameter int unsigned WAKE_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       feed,
    input  logic       play,
    input  logic       disturb,
    input  logic       sleep_req,
    output logic [1:0] energy,
    output logic [1:0] stress,
    output logic [1:0] pleasure,
    output logic [1:0] physical_state,
    output logic       update
);

    localparam int unsigned PW        = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam int unsigned PHASE_MAX = (DROWSY_CYCLES > WAKE_CYCLES) ? DROWSY_CYCLES : WAKE_CYCLES;
    localparam int unsigned TW        = $clog2(PHASE_MAX + 1);

    localparam logic [PW-1:0] PRESC_LAST  = PW'(DECAY_PERIOD - 1);
    localparam logic [TW-1:0] DROWSY_LAST = TW'(DROWSY_CYCLES - 1);
    localparam logic [TW-1:0] WAKE_LAST   = TW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        SLEEP  = 2'b00,
        AWAKE  = 2'b01,
        DROWSY = 2'b10,
        WAKING = 2'b11
    } phys_t;

    phys_t         state, state_next;
    logic [PW-1:0] presc;
    logic [TW-1:0] phase, phase_next;
    logic          tick;
    logic [1:0]    energy_next, stress_next, pleasure_next;
    logic          e_inc, e_dec, s_inc, s_dec, p_inc, p_dec;

    // Opposing events cancel before saturation is applied.
    function automatic logic [1:0] sat_step(input logic [1:0] lvl, input logic inc,
                                            input logic dec);
        if (inc && !dec && lvl != 2'd3) return lvl + 2'd1;
        if (dec && !inc && lvl != 2'd0) return lvl - 2'd1;
        return lvl;
    endfunction

    assign tick           = (presc == PRESC_LAST);
    assign physical_state = state;

    always_comb begin
        e_inc = 1'b0;
        e_dec = 1'b0;
        s_inc = disturb;
        s_dec = 1'b0;
        p_inc = 1'b0;
        p_dec = 1'b0;
        state_next = state;
        unique case (state)
            AWAKE: begin
                e_inc = feed;
                e_dec = tick;
                p_inc = play;
                p_dec = tick;
                if (sleep_req || energy == 2'd0) state_next = DROWSY;
            end
            DROWSY: begin
                if (disturb) state_next = AWAKE;
                else if (phase == DROWSY_LAST) state_next = SLEEP;
            end
            SLEEP: begin
                e_inc = tick;
                s_dec = tick;
                if (disturb || (energy == 2'd3 && !sleep_req)) state_next = WAKING;
            end
            WAKING: begin
                if (phase == WAKE_LAST) state_next = AWAKE;
            end
        endcase

        energy_next   = sat_step(energy, e_inc, e_dec);
        stress_next   = sat_step(stress, s_inc, s_dec);
        pleasure_next = sat_step(pleasure, p_inc, p_dec);

        phase_next = '0;
        if (state_next == state && (state == DROWSY || state == WAKING))
            phase_next = phase + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            phase    <= '0;
            state    <= AWAKE;
            energy   <= 2'd2;
            stress   <= 2'd0;
            pleasure <= 2'd1;
            update   <= 1'b0;
        end else begin
            presc    <= tick ? '0 : presc + PW'(1);
            phase    <= phase_next;
            state    <= state_next;
            energy   <= energy_next;
            stress   <= stress_next;
            pleasure <= pleasure_next;
            update   <= (energy_next != energy) || (stress_next != stress) ||
                        (pleasure_next != pleasure) || (state_next != state);
        end
    end

endmodule

// File: tb/tb_vital_state_integrator.sv
// Scoreboard bench: a cycle-level arithmetic model pushes expected output
// snapshots; a negedge monitor pops one per update pulse and compares.
module tb_vital_state_integrator;

    localparam int DP = 4;
    localparam int DC = 3;
    localparam int WC = 5;

    localparam int S_SLEEP  = 0;
    localparam int S_AWAKE  = 1;
    localparam int S_DROWSY = 2;
    localparam int S_WAKING = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       feed = 1'b0, play = 1'b0, disturb = 1'b0, sleep_req = 1'b0;
    logic [1:0] energy, stress, pleasure, physical_state;
    logic       update;

    vital_state_integrator #(
        .DECAY_PERIOD (DP),
        .DROWSY_CYCLES(DC),
        .WAKE_CYCLES  (WC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .feed          (feed),
        .play          (play),
        .disturb       (disturb),
        .sleep_req     (sleep_req),
        .energy        (energy),
        .stress        (stress),
        .pleasure      (pleasure),
        .physical_state(physical_state),
        .update        (update)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int e;
        int s;
        int p;
        int st;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt     = 0;

    // Reference model state: levels, phase, cycles spent in phase, decay counter.
    int m_e, m_s, m_p, m_st, m_phase, m_presc;

    always @(posedge clk) cnt++;

    function automatic int clamp3(input int v);
        if (v < 0) return 0;
        if (v > 3) return 3;
        return v;
    endfunction

    task automatic model_reset();
        m_e = 2; m_s = 0; m_p = 1; m_st = S_AWAKE; m_phase = 0; m_presc = 0;
    endtask

    task automatic check_reset_values(input string tag);
        n_tests++;
        if (energy !== 2'd2 || stress !== 2'd0 || pleasure !== 2'd1 ||
            physical_state !== 2'b01 || update !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_%s: got e=%0d s=%0d p=%0d st=%0d upd=%0d, want e=2 s=0 p=1 st=1 upd=0",
                     tag, energy, stress, pleasure, physical_state, update);
        end
    endtask

    // Apply one cycle of stimulus; the model predicts the result of the next edge.
    task automatic step(input bit fi, input bit pi, input bit di, input bit si);
        int tick, de, ds, dpl, ne, ns_, np, nst, nph;
        feed = fi; play = pi; disturb = di; sleep_req = si;
        tick = (m_presc == DP - 1) ? 1 : 0;
        de = 0; ds = int'(di); dpl = 0;
        if (m_st == S_AWAKE) begin
            de  = int'(fi) - tick;
            dpl = int'(pi) - tick;
        end else if (m_st == S_SLEEP) begin
            de = tick;
            ds = int'(di) - tick;
        end
        ne = clamp3(m_e + de);
        ns_ = clamp3(m_s + ds);
        np = clamp3(m_p + dpl);
        nst = m_st;
        case (m_st)
            S_AWAKE:  if (si || m_e == 0) nst = S_DROWSY;
            S_DROWSY: if (di) nst = S_AWAKE; else if (m_phase + 1 == DC) nst = S_SLEEP;
            S_SLEEP:  if (di || (m_e == 3 && !si)) nst = S_WAKING;
            default:  if (m_phase + 1 == WC) nst = S_AWAKE;
        endcase
        if (nst != m_st) nph = 0;
        else if (m_st == S_DROWSY || m_st == S_WAKING) nph = m_phase + 1;
        else nph = 0;
        if (ne != m_e || ns_ != m_s || np != m_p || nst != m_st)
            q.push_back('{cyc: cnt + 1, e: ne, s: ns_, p: np, st: nst});
        m_e = ne; m_s = ns_; m_p = np; m_st = nst; m_phase = nph;
        m_presc = (m_presc + 1) % DP;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit si);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, si);
    endtask

    task automatic run_until(input int target, input int budget, input bit si, input string tag);
        int i;
        for (i = 0; i < budget && m_st != target; i++) step(1'b0, 1'b0, 1'b0, si);
        if (m_st != target) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_%s: model state %0d, wanted %0d within %0d cycles",
                     tag, m_st, target, budget);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        feed = 1'b0; play = 1'b0; disturb = 1'b0; sleep_req = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (update) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_update @%0d: e=%0d s=%0d p=%0d st=%0d, no change expected",
                             cnt, energy, stress, pleasure, physical_state);
                end else begin
                    exp_t ex;
                    ex = q.pop_front();
                    n_tests++;
                    if (ex.cyc != cnt || int'(energy) != ex.e || int'(stress) != ex.s ||
                        int'(pleasure) != ex.p || int'(physical_state) != ex.st) begin
                        n_fail++;
                        $display("FAIL outputs @%0d: got e=%0d s=%0d p=%0d st=%0d, want @%0d e=%0d s=%0d p=%0d st=%0d",
                                 cnt, energy, stress, pleasure, physical_state,
                                 ex.cyc, ex.e, ex.s, ex.p, ex.st);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= cnt) begin
                exp_t ex;
                ex = q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_update @%0d: got e=%0d s=%0d p=%0d st=%0d upd=0, want e=%0d s=%0d p=%0d st=%0d upd=1",
                         cnt, energy, stress, pleasure, physical_state, ex.e, ex.s, ex.p, ex.st);
            end
        end
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_values("no_clock");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle decay into DROWSY, SLEEP, recovery through WAKING.
        idle(12, 1'b0);
        run_until(S_AWAKE, 60, 1'b0, "recover");

        // Three feeds before the first tick: only the first changes energy.
        do_reset("pre_feed");
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Feed coincident with a decay tick.
        do_reset("pre_tick_feed");
        idle(DP - 1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Saturated stress then disturb in SLEEP, then full WAKING phase.
        do_reset("pre_sleep");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        run_until(S_SLEEP, 20, 1'b1, "to_sleep");
        step(1'b0, 1'b0, 1'b1, 1'b1);
        run_until(S_AWAKE, 20, 1'b1, "waking");

        // Disturb in DROWSY returns to AWAKE next edge.
        do_reset("pre_drowsy");
        run_until(S_DROWSY, 5, 1'b1, "to_drowsy");
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);

        // Asynchronous reset mid-DROWSY.
        run_until(S_DROWSY, 5, 1'b1, "to_drowsy2");
        step(1'b0, 1'b0, 1'b0, 1'b1);
        do_reset("mid_drowsy");
        idle(DP + 1, 1'b0);

        // Randomized traffic with occasional asynchronous resets.
        begin
            bit sreq;
            sreq = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 19) == 0) sreq = ~sreq;
                if ($urandom_range(0, 599) == 0) do_reset("random");
                step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 15) == 0, sreq);
            end
        end
        idle(3, 1'b0);
        @(negedge clk);
        #1;

        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected updates never seen, want 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vital_state_integrator.md
VITAL_STATE_INTEGRATOR -- requirements
Module: vital_state_integrator

Interface
REQ-001 Parameter: DECAY_PERIOD, 1024, clock cycles per decay tick (>=2).
REQ-002 Parameter: DROWSY_CYCLES, 64, cycles held in DROWSY before SLEEP (>=1).
REQ-003 Parameter: WAKE_CYCLES, 16, cycles held in WAKING before AWAKE (>=1).
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: feed  input  1  one-cycle event pulse, raises energy.
REQ-007 Port: play  input  1  one-cycle event pulse, raises pleasure.
REQ-008 Port: disturb  input  1  one-cycle event pulse, raises stress and interrupts rest.
REQ-009 Port: sleep_req  input  1  level request to go to sleep.
REQ-010 Port: energy  output  2  registered level, 0=LOW..3=HIGH.
REQ-011 Port: stress  output  2  registered level, 0..3.
REQ-012 Port: pleasure  output  2  registered level, 0..3.
REQ-013 Port: physical_state  output  2  registered state: 00 SLEEP, 01 AWAKE, 10 DROWSY, 11 WAKING.
REQ-014 Port: update  output  1  one-cycle pulse, high in the first cycle any of energy/stress/pleasure/physical_state shows a new value.

Function
REQ-015 Prescaler counts 0..DECAY_PERIOD-1 and wraps; decay tick is asserted for the one cycle the count equals DECAY_PERIOD-1; it runs in every state.
REQ-016 Levels are 2-bit saturating: increment at 3 stays 3, decrement at 0 stays 0; no wrap-around ever.
REQ-017 AWAKE: tick gives energy -1, pleasure -1; feed gives energy +1; play gives pleasure +1; disturb gives stress +1.
REQ-018 SLEEP: tick gives energy +1, stress -1; feed and play are ignored; disturb gives stress +1.
REQ-019 DROWSY and WAKING: tick has no effect on levels; feed and play are ignored; disturb gives stress +1.
REQ-020 Simultaneous events on one level sum before saturation: +1 and -1 in the same cycle leave the level unchanged; distinct levels update independently.
REQ-021 FSM AWAKE->DROWSY when sleep_req=1 or registered energy=0.
REQ-022 FSM DROWSY->AWAKE on disturb, which takes priority over the timer; otherwise DROWSY->SLEEP after exactly DROWSY_CYCLES cycles in DROWSY.
REQ-023 FSM SLEEP->WAKING on disturb, or when registered energy=3 and sleep_req=0.
REQ-024 FSM WAKING->AWAKE after exactly WAKE_CYCLES cycles in WAKING; disturb in WAKING does not shorten it.
REQ-025 Phase timer clears on every FSM transition and counts only in DROWSY/WAKING; width suffices for max(DROWSY_CYCLES, WAKE_CYCLES).
REQ-026 FSM decisions use registered values only; level updates and the state transition in the same cycle both take effect at the same edge, with level rules chosen by the current state.
REQ-027 update is registered: it is high if and only if the outputs changed at the preceding edge; a saturated event producing no change gives no pulse.
REQ-028 Latency: an event pulse sampled at edge N is visible on the outputs after edge N, with update high in the same cycle.

Reset
REQ-029 While rst_n=0, independent of clk: energy=2, stress=0, pleasure=1, physical_state=01 (AWAKE), update=0, prescaler=0, phase timer=0.
REQ-030 Reset asserted mid-operation, in any state or during a tick, aborts immediately; after release the prescaler restarts at 0 and the first tick falls DECAY_PERIOD cycles later.

Verification
REQ-031 Reset: rst_n low with no clock edge -> outputs 2/0/1/01, update=0.
REQ-032 DECAY_PERIOD=4, DROWSY_CYCLES=3, no stimulus -> energy 2->1 at tick 1, 1->0 at tick 2; DROWSY on next edge; SLEEP 3 cycles later; update pulses at each change.
REQ-033 Three feed pulses in AWAKE from energy=2 -> energy=3, one update pulse only; 2nd and 3rd pulses give no change and no pulse.
REQ-034 feed coincident with tick in AWAKE -> energy unchanged, pleasure 1->0, one update pulse.
REQ-035 In SLEEP with stress=3, disturb -> stress stays 3, state WAKING; AWAKE after exactly WAKE_CYCLES; disturb in DROWSY -> AWAKE on next edge.
REQ-036 rst_n dropped asynchronously mid-DROWSY -> outputs return to reset values before the next clk edge.
